// File: rtl/dkong_obj_dma_sched_if.sv
// Signal bundle for dkong_obj_dma_sched: pixel enable, vblank, CPU hold handshake,
// source RAM read port and object buffer write port.
interface dkong_obj_dma_sched_if;
   logic       I_CE;
   logic       I_V_BLANKn;
   logic       I_CPU_HLDA;
   logic       O_CPU_HOLD;
   logic [9:0] O_SRC_A;
   logic [7:0] I_SRC_D;
   logic [8:0] O_DST_A;
   logic [7:0] O_DST_D;
   logic       O_DST_WE;
   logic       O_BANK;
   logic       O_BUSY;
   logic       O_OVERRUN;

   modport master (
      input  I_CE, I_V_BLANKn, I_CPU_HLDA, I_SRC_D,
      output O_CPU_HOLD, O_SRC_A, O_DST_A, O_DST_D, O_DST_WE, O_BANK, O_BUSY, O_OVERRUN
   );

   modport slave (
      output I_CE, I_V_BLANKn, I_CPU_HLDA, I_SRC_D,
      input  O_CPU_HOLD, O_SRC_A, O_DST_A, O_DST_D, O_DST_WE, O_BANK, O_BUSY, O_OVERRUN
   );
endinterface

// File: rtl/dkong_obj_dma_sched.sv
// Frame-synchronous object DMA: copies LEN bytes from CPU work RAM to the object buffer at vblank start.
// Define DKONG_OBJ_DMA_DBUF_EN for a double-buffered object RAM (write bank = ~O_BANK, O_DST_A is the in-bank offset).
module dkong_obj_dma_sched #(
   parameter int unsigned LEN      = 384,
   parameter logic [9:0]  SRC_BASE = 10'h100
) (
   input logic                   I_CLK,
   input logic                   I_RST,
   dkong_obj_dma_sched_if.master bus
);
   localparam logic [8:0] LAST_IDX = 9'(LEN - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_COPY  = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic       vbl_q, vbl_d;
   logic [8:0] n_q, n_d;
   logic       hold_q, hold_d;
   logic [9:0] src_a_q, src_a_d;
   logic [8:0] dst_a_q, dst_a_d;
   logic [7:0] dst_d_q, dst_d_d;
   logic       we_q, we_d;
   logic       bank_q, bank_d;
   logic       busy_q, busy_d;
   logic       ovr_q, ovr_d;
   logic       start_s;
   logic       vbl_end_s;

   assign start_s   = vbl_q & ~bus.I_V_BLANKn;
   assign vbl_end_s = bus.I_V_BLANKn;

   // Next-state and output decode; everything advances only on a pixel step
   always_comb begin
      state_d = state_q;
      vbl_d   = vbl_q;
      n_d     = n_q;
      hold_d  = hold_q;
      src_a_d = src_a_q;
      dst_a_d = dst_a_q;
      dst_d_d = dst_d_q;
      we_d    = 1'b0;
      bank_d  = bank_q;
      ovr_d   = ovr_q;
      if (bus.I_CE) begin
         vbl_d = bus.I_V_BLANKn;
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_d = ST_REQ;
                  hold_d  = 1'b1;
                  ovr_d   = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REQ: begin
               if (vbl_end_s) begin
                  state_d = ST_IDLE;
                  hold_d  = 1'b0;
                  ovr_d   = 1'b1;
               end else if (bus.I_CPU_HLDA) begin
                  state_d = ST_COPY;
                  n_d     = 9'd0;
               end else begin
                  state_d = ST_REQ;
               end
            end
            ST_COPY: begin
               // Each step issues address n and writes byte n-1, whose read was issued last step
               if (vbl_end_s) begin
                  state_d = ST_IDLE;
                  hold_d  = 1'b0;
                  ovr_d   = 1'b1;
               end else if (bus.I_CPU_HLDA) begin
                  src_a_d = SRC_BASE + {1'b0, n_q};
                  if (n_q != 9'd0) begin
                     we_d    = 1'b1;
                     dst_a_d = n_q - 9'd1;
                     dst_d_d = bus.I_SRC_D;
                  end else begin
                     dst_a_d = dst_a_q;
                  end
                  if (n_q == LAST_IDX) begin
                     state_d = ST_FLUSH;
                  end else begin
                     n_d = n_q + 9'd1;
                  end
               end else begin
                  state_d = ST_COPY;
               end
            end
            ST_FLUSH: begin
               // A granted final write wins over a coincident vblank end
               if (bus.I_CPU_HLDA) begin
                  we_d    = 1'b1;
                  dst_a_d = LAST_IDX;
                  dst_d_d = bus.I_SRC_D;
                  state_d = ST_DONE;
               end else if (vbl_end_s) begin
                  state_d = ST_IDLE;
                  hold_d  = 1'b0;
                  ovr_d   = 1'b1;
               end else begin
                  state_d = ST_FLUSH;
               end
            end
            ST_DONE: begin
               hold_d  = 1'b0;
               state_d = ST_IDLE;
`ifdef DKONG_OBJ_DMA_DBUF_EN
               bank_d  = ~bank_q;
`endif
            end
            default: begin
               state_d = ST_IDLE;
               hold_d  = 1'b0;
            end
         endcase
      end else begin
         vbl_d = vbl_q;
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset overrides the pixel enable
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state_q <= ST_IDLE;
         vbl_q   <= 1'b0;
         n_q     <= 9'd0;
         hold_q  <= 1'b0;
         src_a_q <= SRC_BASE;
         dst_a_q <= 9'd0;
         dst_d_q <= 8'd0;
         we_q    <= 1'b0;
         bank_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vbl_q   <= vbl_d;
         n_q     <= n_d;
         hold_q  <= hold_d;
         src_a_q <= src_a_d;
         dst_a_q <= dst_a_d;
         dst_d_q <= dst_d_d;
         we_q    <= we_d;
         bank_q  <= bank_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.O_CPU_HOLD = hold_q;
   assign bus.O_SRC_A    = src_a_q;
   assign bus.O_DST_A    = dst_a_q;
   assign bus.O_DST_D    = dst_d_q;
   assign bus.O_DST_WE   = we_q;
   assign bus.O_BANK     = bank_q;
   assign bus.O_BUSY     = busy_q;
   assign bus.O_OVERRUN  = ovr_q;
endmodule
